// File: rtl/sb_rx_fifo_deser.sv
// rtl/sb_rx_fifo_deser.sv - sideband RX: pin oversampling, LSB-first deserialiser, show-ahead message FIFO
`timescale 1ns/1ps
module sb_rx_fifo_deser #(
    parameter int MSG_WIDTH   = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                               clk_800MHz,
    input  logic                               reset,
    input  logic                               enable_i,
    input  logic                               clkPin_i,
    input  logic                               dataPin_i,
    input  logic                               ready_i,
    input  logic                               clear_err_i,
    output logic [MSG_WIDTH-1:0]               data_o,
    output logic                               valid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
    output logic                               overflow_o,
    output logic                               frame_err_o
);
    localparam int CNT_W  = $clog2(MSG_WIDTH);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev;
    logic                   clk_sync;
    logic                   data_sync;
    logic                   fall;

    logic [MSG_WIDTH-1:0]   shift_reg;
    logic [MSG_WIDTH-1:0]   shift_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic [IDLE_W-1:0]      idle_cnt;
    logic                   push;

    logic [MSG_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   full;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;

    assign clk_sync   = clk_sync_q[SYNC_STAGES-1];
    assign data_sync  = data_sync_q[SYNC_STAGES-1];
    assign fall       = clk_prev & ~clk_sync;
    assign shift_next = {data_sync, shift_reg[MSG_WIDTH-1:1]};
    assign push       = fall & enable_i & (bit_cnt == CNT_W'(MSG_WIDTH - 1));

    // clk chain resets high so leaving reset never fabricates a falling edge
    always_ff @(posedge clk_800MHz) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '0;
            clk_prev    <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], clkPin_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], dataPin_i};
            clk_prev    <= clk_sync;
        end
    end

    always_ff @(posedge clk_800MHz) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            if (!enable_i) begin
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else if (fall) begin
                shift_reg <= shift_next;
                bit_cnt   <= push ? '0 : bit_cnt + 1'b1;
                idle_cnt  <= '0;
            end else if (bit_cnt != '0) begin
                // a stalled partial message is abandoned so the next word frames cleanly
                if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    bit_cnt     <= '0;
                    idle_cnt    <= '0;
                    frame_err_o <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    assign valid_o = (count_o != '0);
    assign data_o  = mem[rd_ptr];
    assign full    = (count_o == OCC_W'(FIFO_DEPTH));
    assign pop     = valid_o & ready_i;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk_800MHz) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shift_next;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
            // a fresh drop outranks a coincident clear
            if (drop)             overflow_o <= 1'b1;
            else if (clear_err_i) overflow_o <= 1'b0;
        end
    end
endmodule

// File: doc/sb_rx_fifo_deser.md
Name: sb_rx_fifo_deser

Overview:
- Single-clock sideband receiver, successor to the dual-clock sideband RX.
- Oversamples the forwarded serial clock and data pins on clk_800MHz and deserialises LSB-first MSG_WIDTH-bit messages.
- Queues completed messages in a parametrised show-ahead FIFO with a valid/ready output.
- Adds idle-timeout framing recovery, overflow detection and occupancy reporting; sits between the sideband pins and the sideband message decoder.

Parameters:
- MSG_WIDTH, 64, bits per sideband message; ≥8.
- FIFO_DEPTH, 4, message slots; power of 2, ≥2.
- SYNC_STAGES, 2, synchroniser flops on clkPin_i and dataPin_i; ≥2.
- TIMEOUT_CYC, 64, clk cycles without a serial falling edge before a partial message is discarded; ≥4.

Ports:
- clk_800MHz  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable_i  in  1  deserialiser enable; FIFO read side ignores it.
- clkPin_i  in  1  asynchronous serial clock from the remote TX.
- dataPin_i  in  1  asynchronous serial data; valid at clkPin_i falling edge.
- ready_i  in  1  consumer accepts the head message when high with valid_o.
- clear_err_i  in  1  clears sticky overflow_o.
- data_o  out  MSG_WIDTH  FIFO head message.
- valid_o  out  1  FIFO non-empty.
- count_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- overflow_o  out  1  sticky: a completed message was dropped.
- frame_err_o  out  1  one-cycle pulse: partial message discarded on timeout.

Behaviour:
- Reset (synchronous, active-high), applied at any time including mid-message:
  - sync chains load 1 for clk and 0 for data;
  - shift register, bit_cnt, idle counter, pointers and count clear;
  - all outputs go to 0 (data_o reads mem[0], which is also cleared).
- Pin sampling:
  - each pin passes through SYNC_STAGES flops; clk_prev registers the last sync stage;
  - fall = clk_prev & ~clk_sync.
  - Pins must hold each serial half-period ≥ 2 clk_800MHz cycles; faster input is out of scope.
- Deserialiser, on a cycle with fall & enable_i:
  - shift_reg <= {data_sync, shift_reg[MSG_WIDTH-1:1]};
  - bit_cnt increments;
  - at bit_cnt == MSG_WIDTH-1 the completed word {data_sync, shift_reg[MSG_WIDTH-1:1]} is pushed that same edge and bit_cnt wraps to 0.
- enable_i low: bit_cnt and idle counter forced to 0; the partial message is silently dropped with no frame_err_o.
- Timeout:
  - the idle counter counts cycles since the last fall while bit_cnt != 0;
  - on reaching TIMEOUT_CYC: bit_cnt <= 0, idle counter <= 0, frame_err_o = 1 for exactly one cycle;
  - with bit_cnt == 0 the idle counter holds 0 and never fires.
- FIFO:
  - show-ahead: data_o = mem[rd_ptr], valid_o = (count != 0);
  - pop = valid_o & ready_i;
  - pointers wrap modulo FIFO_DEPTH.
- Push when count < FIFO_DEPTH: written; count +1 unless a simultaneous pop (count unchanged).
- Push when count == FIFO_DEPTH:
  - with a simultaneous pop, the push is accepted and count is unchanged;
  - without one, the word is dropped, FIFO contents are untouched and overflow_o <= 1.
- overflow_o clears only on reset or clear_err_i. If clear_err_i coincides with a new drop, the set wins.
- ready_i while empty has no effect.
- Latency: valid_o rises after the (SYNC_STAGES+1)-th rising clk edge, counted from the first edge that samples the final clkPin_i low. Example: 3 edges for SYNC_STAGES=2, empty FIFO.
- Ordering is strictly FIFO; no message is duplicated or reordered.

Test Plan:
- Single message: serialise 64'hDEADBEEF_CAFEF00D LSB-first at 100 MHz-equivalent (4 clk high / 4 low), ready_i=0 -> valid_o=1 with data_o=64'hDEADBEEF_CAFEF00D, count_o=1, exactly 3 clk edges after the final low sample.
- Overflow: send 5 messages (0x1..0x5) with ready_i=0 -> count_o=4, overflow_o=1 after the 5th; pops then return 0x1,0x2,0x3,0x4. Pulse clear_err_i -> overflow_o=0.
- Full with simultaneous pop: FIFO full with 0x1..0x4, hold ready_i=1 on the cycle the 5th word (0x5) completes -> no overflow, count_o stays 4, subsequent order 0x2,0x3,0x4,0x5.
- Timeout: send 20 bits then stop clkPin_i high for 64 cycles -> frame_err_o one-cycle pulse. A following full message 0xA5A5 is received intact, valid_o=1.
- Reset mid-message: assert reset after 30 bits with 2 words queued -> next cycle count_o=0, valid_o=0, data_o=0. A subsequent 64-bit message is received correctly.
- Wrap and backpressure: stream 10 messages (0x10..0x19) with ready_i toggling 1-of-3 cycles -> all 10 popped in order, overflow_o=0, pointers wrap twice.
